// File: rtl/peripheral_multi_counter_pkg.sv
// Shared types for the multi-channel counter peripheral: counting modes,
// pending-bit positions and the per-channel configuration record.
package peripheral_multi_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    localparam int PEND_TERM = 0;
    localparam int PEND_CMP  = 1;

    // mode is kept as a raw 2-bit field so the reserved encoding reads back as written
    typedef struct packed {
        logic       en;
        logic       dir;
        logic       ire;
        logic [1:0] mode;
    } chan_cfg_t;

    function automatic logic irq_request(input chan_cfg_t cfg, input logic [1:0] pend);
        return cfg.ire & (|pend);
    endfunction

endpackage

// File: rtl/peripheral_counter_channel.sv
// One counter channel: count, compare and config registers, plus terminal and
// compare-arrival detection feeding sticky write-1-to-clear pending bits.
module peripheral_counter_channel
    import peripheral_multi_counter_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int unsigned CMP_RESET = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_we,
    input  logic [WIDTH-1:0] count_in,
    input  logic             config_we,
    input  chan_cfg_t        cfg_in,
    input  logic             compare_we,
    input  logic [WIDTH-1:0] compare_in,
    input  logic             irq_clr_we,
    input  logic [1:0]       irq_clr_in,
    output logic [WIDTH-1:0] count_out,
    output chan_cfg_t        cfg_out,
    output logic [WIDTH-1:0] compare_out,
    output logic [1:0]       pend_out
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] compare_q, compare_d;
    chan_cfg_t        cfg_q, cfg_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       pend_set_s, pend_clr_s;
    logic             at_term_s;
    logic [WIDTH-1:0] stepped_s;

    // Next-state: a count write pre-empts counting, so it raises no terminal or compare event.
    always_comb begin
        count_d    = count_q;
        cfg_d      = cfg_q;
        compare_d  = compare_q;
        pend_set_s = 2'b00;
        at_term_s  = cfg_q.dir ? (count_q == '0) : (count_q == '1);
        stepped_s  = cfg_q.dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        if (count_we) begin
            count_d = count_in;
        end else if (cfg_q.en) begin
            if (at_term_s) begin
                pend_set_s[PEND_TERM] = 1'b1;
                case (cfg_q.mode)
                    MODE_SAT:     count_d = count_q;
                    MODE_ONESHOT: begin
                        count_d  = count_q;
                        cfg_d.en = 1'b0;
                    end
                    default:      count_d = stepped_s;
                endcase
            end else begin
                count_d = stepped_s;
            end
            // compare fires only on arrival, never while a saturated value sits on it
            if ((count_d != count_q) && (count_d == compare_q)) begin
                pend_set_s[PEND_CMP] = 1'b1;
            end else begin
                pend_set_s[PEND_CMP] = 1'b0;
            end
        end else begin
            count_d = count_q;
        end
        if (config_we) begin
            cfg_d = cfg_in;
        end else begin
            cfg_d = cfg_d;
        end
        if (compare_we) begin
            compare_d = compare_in;
        end else begin
            compare_d = compare_q;
        end
        pend_clr_s = irq_clr_we ? irq_clr_in : 2'b00;
        pend_d     = (pend_q & ~pend_clr_s) | pend_set_s;
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            cfg_q     <= '0;
            compare_q <= WIDTH'(CMP_RESET);
            pend_q    <= 2'b00;
        end else begin
            count_q   <= count_d;
            cfg_q     <= cfg_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end

    assign count_out   = count_q;
    assign cfg_out     = cfg_q;
    assign compare_out = compare_q;
    assign pend_out    = pend_q;

endmodule

// File: rtl/peripheral_multi_counter_core.sv
// Multi-channel counter core: write decode onto the channels, combinational
// read-back mux on chan_sel and the registered interrupt OR.
module peripheral_multi_counter_core
    import peripheral_multi_counter_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          CHANNELS  = 4,
    parameter int unsigned CMP_RESET = 1000,
    localparam int         CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH_W-1:0]  chan_sel,
    input  logic             count_we,
    input  logic [WIDTH-1:0] count_in,
    input  logic             config_we,
    input  logic             count_en_in,
    input  logic             count_dir_in,
    input  logic             count_ire_in,
    input  logic [1:0]       count_mode_in,
    input  logic             compare_we,
    input  logic [WIDTH-1:0] compare_in,
    input  logic             irq_clr_we,
    input  logic [1:0]       irq_clr_in,
    output logic [WIDTH-1:0] count_out,
    output logic             count_en_out,
    output logic             count_dir_out,
    output logic             count_ire_out,
    output logic [1:0]       count_mode_out,
    output logic [WIDTH-1:0] compare_out,
    output logic             count_lt_cmp_out,
    output logic [1:0]       irq_pending_out,
    output logic             irq_out
);

    logic             sel_valid_s;
    chan_cfg_t        cfg_in_s;
    logic [WIDTH-1:0] ch_count_s   [CHANNELS];
    logic [WIDTH-1:0] ch_compare_s [CHANNELS];
    chan_cfg_t        ch_cfg_s     [CHANNELS];
    logic [1:0]       ch_pend_s    [CHANNELS];
    logic             irq_q, irq_d;

    // one extra bit so CHANNELS itself is representable when it is a power of two
    assign sel_valid_s = ({1'b0, chan_sel} < (CH_W + 1)'(CHANNELS));
    assign cfg_in_s    = '{en: count_en_in, dir: count_dir_in, ire: count_ire_in, mode: count_mode_in};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic hit_s;
        assign hit_s = sel_valid_s && (chan_sel == CH_W'(c));

        peripheral_counter_channel #(
            .WIDTH     (WIDTH),
            .CMP_RESET (CMP_RESET)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .count_we    (count_we & hit_s),
            .count_in    (count_in),
            .config_we   (config_we & hit_s),
            .cfg_in      (cfg_in_s),
            .compare_we  (compare_we & hit_s),
            .compare_in  (compare_in),
            .irq_clr_we  (irq_clr_we & hit_s),
            .irq_clr_in  (irq_clr_in),
            .count_out   (ch_count_s[c]),
            .cfg_out     (ch_cfg_s[c]),
            .compare_out (ch_compare_s[c]),
            .pend_out    (ch_pend_s[c])
        );
    end

    // Read-back mux; an unimplemented channel reads as all zeros.
    always_comb begin
        count_out        = '0;
        count_en_out     = 1'b0;
        count_dir_out    = 1'b0;
        count_ire_out    = 1'b0;
        count_mode_out   = 2'b00;
        compare_out      = '0;
        count_lt_cmp_out = 1'b0;
        irq_pending_out  = 2'b00;
        if (sel_valid_s) begin
            count_out        = ch_count_s[chan_sel];
            count_en_out     = ch_cfg_s[chan_sel].en;
            count_dir_out    = ch_cfg_s[chan_sel].dir;
            count_ire_out    = ch_cfg_s[chan_sel].ire;
            count_mode_out   = ch_cfg_s[chan_sel].mode;
            compare_out      = ch_compare_s[chan_sel];
            count_lt_cmp_out = ch_count_s[chan_sel] < ch_compare_s[chan_sel];
            irq_pending_out  = ch_pend_s[chan_sel];
        end else begin
            count_out = '0;
        end
    end

    // Interrupt request OR over all channels.
    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            irq_d = irq_d | irq_request(ch_cfg_s[i], ch_pend_s[i]);
        end
    end

    // Interrupt output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_out = irq_q;

endmodule

// File: tb/tb_peripheral_multi_counter_core.sv
// Randomised and directed bench for peripheral_multi_counter_core, checked
// against a per-channel arithmetic model of the counter peripheral.
module tb_peripheral_multi_counter_core;

    localparam int          W    = 32;
    localparam int          NCH  = 5;
    localparam int          CW   = 3;
    localparam logic [31:0] MAXV = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] chan_sel;
    logic          count_we, config_we, compare_we, irq_clr_we;
    logic [W-1:0]  count_in, compare_in;
    logic          count_en_in, count_dir_in, count_ire_in;
    logic [1:0]    count_mode_in, irq_clr_in;
    logic [W-1:0]  count_out, compare_out;
    logic          count_en_out, count_dir_out, count_ire_out, count_lt_cmp_out, irq_out;
    logic [1:0]    count_mode_out, irq_pending_out;

    peripheral_multi_counter_core #(.WIDTH(W), .CHANNELS(NCH), .CMP_RESET(1000)) dut (
        .clk(clk), .reset(reset), .chan_sel(chan_sel),
        .count_we(count_we), .count_in(count_in),
        .config_we(config_we), .count_en_in(count_en_in), .count_dir_in(count_dir_in),
        .count_ire_in(count_ire_in), .count_mode_in(count_mode_in),
        .compare_we(compare_we), .compare_in(compare_in),
        .irq_clr_we(irq_clr_we), .irq_clr_in(irq_clr_in),
        .count_out(count_out), .count_en_out(count_en_out), .count_dir_out(count_dir_out),
        .count_ire_out(count_ire_out), .count_mode_out(count_mode_out),
        .compare_out(compare_out), .count_lt_cmp_out(count_lt_cmp_out),
        .irq_pending_out(irq_pending_out), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_cnt [NCH];
    logic [31:0] m_cmp [NCH];
    logic        m_en  [NCH];
    logic        m_dir [NCH];
    logic        m_ire [NCH];
    logic [1:0]  m_mode[NCH];
    logic [1:0]  m_pend[NCH];
    logic        m_irq;

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_cnt[ch] = 32'd0; m_cmp[ch] = 32'd1000; m_en[ch] = 1'b0; m_dir[ch] = 1'b0;
            m_ire[ch] = 1'b0; m_mode[ch] = 2'd0; m_pend[ch] = 2'b00;
        end
        m_irq = 1'b0;
    endtask

    task automatic idle();
        count_we = 1'b0; config_we = 1'b0; compare_we = 1'b0; irq_clr_we = 1'b0;
        irq_clr_in = 2'b00;
    endtask

    // One clock: derive next model state from the current inputs, clock, commit, settle.
    task automatic tick();
        logic [31:0] nc [NCH];
        logic        ne [NCH];
        logic [1:0]  ps [NCH];
        logic        hit[NCH];
        logic        nirq;
        nirq = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            hit[ch] = (int'(chan_sel) == ch);
            nirq    = nirq | (m_ire[ch] && (m_pend[ch] != 2'b00));
            nc[ch]  = m_cnt[ch]; ne[ch] = m_en[ch]; ps[ch] = 2'b00;
            if (hit[ch] && count_we) begin
                nc[ch] = count_in;
            end else if (m_en[ch]) begin
                if ((!m_dir[ch] && m_cnt[ch] == MAXV) || (m_dir[ch] && m_cnt[ch] == 32'd0)) begin
                    ps[ch][0] = 1'b1;
                    if (m_mode[ch] == 2'd2) ne[ch] = 1'b0;
                    if (m_mode[ch] != 2'd1 && m_mode[ch] != 2'd2) nc[ch] = m_dir[ch] ? MAXV : 32'd0;
                end else begin
                    nc[ch] = m_dir[ch] ? m_cnt[ch] - 32'd1 : m_cnt[ch] + 32'd1;
                end
                if (nc[ch] != m_cnt[ch] && nc[ch] == m_cmp[ch]) ps[ch][1] = 1'b1;
            end
            if (hit[ch] && config_we) ne[ch] = count_en_in;
        end
        @(posedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            m_cnt[ch] = nc[ch];
            m_en[ch]  = ne[ch];
            if (hit[ch] && config_we) begin
                m_dir[ch] = count_dir_in; m_ire[ch] = count_ire_in; m_mode[ch] = count_mode_in;
            end
            if (hit[ch] && compare_we) m_cmp[ch] = compare_in;
            m_pend[ch] = (m_pend[ch] & ~((hit[ch] && irq_clr_we) ? irq_clr_in : 2'b00)) | ps[ch];
        end
        m_irq = nirq;
        #1;
    endtask

    task automatic set_cfg(input logic en, input logic dir, input logic ire, input logic [1:0] mode);
        config_we = 1'b1; count_en_in = en; count_dir_in = dir; count_ire_in = ire; count_mode_in = mode;
    endtask

    function automatic logic [31:0] near_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 4));
            1:       return MAXV - 32'($urandom_range(0, 4));
            2:       return 32'd998 + 32'($urandom_range(0, 4));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; chan_sel = '0; idle();
        count_in = '0; compare_in = '0; count_en_in = 1'b0; count_dir_in = 1'b0;
        count_ire_in = 1'b0; count_mode_in = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (count_out !== 32'd0 || compare_out !== 32'd1000 || count_en_out !== 1'b0 ||
            count_mode_out !== 2'd0 || irq_pending_out !== 2'b00 || irq_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: count=%0d cmp=%0d en=%b mode=%0d pend=%b irq=%b, want 0/1000/0/0/00/0",
                     count_out, compare_out, count_en_out, count_mode_out, irq_pending_out, irq_out);
        end
        #2 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_compare_ch0();
        chan_sel = 3'd0; count_we = 1'b1; count_in = 32'd0; set_cfg(1'b1, 1'b0, 1'b1, 2'd0);
        tick(); idle();
        repeat (999) tick();
        n_cmp++;
        if (count_out !== 32'd999 || count_lt_cmp_out !== 1'b1 || irq_pending_out[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL cmp_before: count=%0d lt=%b pend=%b, want 999/1/0x", count_out, count_lt_cmp_out, irq_pending_out);
        end
        tick();
        n_cmp++;
        if (count_out !== 32'd1000 || count_lt_cmp_out !== 1'b0 || irq_pending_out !== 2'b10 || irq_out !== 1'b0) begin
            n_bad++;
            $display("FAIL cmp_arrive: count=%0d lt=%b pend=%b irq=%b, want 1000/0/10/0",
                     count_out, count_lt_cmp_out, irq_pending_out, irq_out);
        end
        tick();
        n_cmp++;
        if (irq_out !== 1'b1 || count_out !== 32'd1001 || irq_pending_out !== 2'b10) begin
            n_bad++;
            $display("FAIL cmp_irq: irq=%b count=%0d pend=%b, want 1/1001/10", irq_out, count_out, irq_pending_out);
        end
        set_cfg(1'b0, 1'b0, 1'b0, 2'd0); irq_clr_we = 1'b1; irq_clr_in = 2'b11;
        tick(); idle(); tick();
        n_cmp++;
        if (irq_out !== 1'b0 || irq_pending_out !== 2'b00) begin
            n_bad++;
            $display("FAIL cmp_clear: irq=%b pend=%b, want 0/00", irq_out, irq_pending_out);
        end
    endtask

    task automatic test_saturate_ch1();
        chan_sel = 3'd1; count_we = 1'b1; count_in = 32'd2; set_cfg(1'b1, 1'b1, 1'b0, 2'd1);
        tick(); idle();
        tick(); tick();
        n_cmp++;
        if (count_out !== 32'd0 || irq_pending_out[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_reach0: count=%0d pend=%b, want 0/x0", count_out, irq_pending_out);
        end
        tick();
        n_cmp++;
        if (count_out !== 32'd0 || irq_pending_out[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_hold: count=%0d pend=%b, want 0/x1", count_out, irq_pending_out);
        end
        irq_clr_we = 1'b1; irq_clr_in = 2'b01;
        tick(); idle();
        n_cmp++;
        if (irq_pending_out[0] !== 1'b1 || count_out !== 32'd0) begin
            n_bad++;
            $display("FAIL sat_setwins: pend=%b count=%0d, want x1/0", irq_pending_out, count_out);
        end
        set_cfg(1'b0, 1'b1, 1'b0, 2'd1);
        tick(); idle(); irq_clr_we = 1'b1; irq_clr_in = 2'b01;
        tick(); idle();
        n_cmp++;
        if (irq_pending_out[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_clear: pend=%b, want x0", irq_pending_out);
        end
    endtask

    task automatic test_oneshot_ch2();
        chan_sel = 3'd2; count_we = 1'b1; count_in = MAXV - 32'd1; set_cfg(1'b1, 1'b0, 1'b0, 2'd2);
        tick(); idle(); tick();
        n_cmp++;
        if (count_out !== MAXV || count_en_out !== 1'b1 || irq_pending_out[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL os_top: count=%h en=%b pend=%b, want ffffffff/1/x0", count_out, count_en_out, irq_pending_out);
        end
        tick(); tick();
        n_cmp++;
        if (count_out !== MAXV || count_en_out !== 1'b0 || irq_pending_out[0] !== 1'b1 || count_mode_out !== 2'd2) begin
            n_bad++;
            $display("FAIL os_stop: count=%h en=%b pend=%b mode=%0d, want ffffffff/0/x1/2",
                     count_out, count_en_out, irq_pending_out, count_mode_out);
        end
    endtask

    task automatic test_wrap_ch3();
        chan_sel = 3'd3; count_we = 1'b1; count_in = MAXV; set_cfg(1'b1, 1'b0, 1'b0, 2'd0);
        tick(); idle(); tick();
        n_cmp++;
        if (count_out !== 32'd0 || irq_pending_out[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_zero: count=%h pend=%b, want 0/x1", count_out, irq_pending_out);
        end
        tick(); count_we = 1'b1; count_in = 32'd5;
        tick(); idle();
        n_cmp++;
        if (count_out !== 32'd5) begin
            n_bad++;
            $display("FAIL wrap_write_prio: count=%0d, want 5", count_out);
        end
        tick();
        n_cmp++;
        if (count_out !== 32'd6) begin
            n_bad++;
            $display("FAIL wrap_after_write: count=%0d, want 6", count_out);
        end
        set_cfg(1'b0, 1'b0, 1'b0, 2'd0); tick(); idle();
    endtask

    task automatic test_invalid_sel();
        chan_sel = 3'd5; count_we = 1'b1; count_in = 32'd77; compare_we = 1'b1; compare_in = 32'd3;
        set_cfg(1'b1, 1'b1, 1'b1, 2'd1); irq_clr_we = 1'b1; irq_clr_in = 2'b11;
        tick(); idle();
        for (int s = 5; s < 8; s++) begin
            chan_sel = CW'(s); #1;
            n_cmp++;
            if (count_out !== 32'd0 || compare_out !== 32'd0 || count_en_out !== 1'b0 ||
                count_mode_out !== 2'd0 || irq_pending_out !== 2'b00 || count_lt_cmp_out !== 1'b0) begin
                n_bad++;
                $display("FAIL invalid_read sel=%0d: count=%0d cmp=%0d en=%b pend=%b, want zeros",
                         s, count_out, compare_out, count_en_out, irq_pending_out);
            end
        end
        for (int ch = 0; ch < NCH; ch++) begin
            chan_sel = CW'(ch); #1;
            n_cmp++;
            if (count_out !== m_cnt[ch] || compare_out !== m_cmp[ch] || irq_pending_out !== m_pend[ch]) begin
                n_bad++;
                $display("FAIL invalid_nowrite ch%0d: count=%0d cmp=%0d pend=%b, want %0d/%0d/%b",
                         ch, count_out, compare_out, irq_pending_out, m_cnt[ch], m_cmp[ch], m_pend[ch]);
            end
        end
    endtask

    task automatic test_concurrent_random();
        logic [31:0] e_cnt, e_cmp;
        logic        e_en, e_dir, e_ire, e_lt;
        logic [1:0]  e_mode, e_pend;
        int          ch;
        for (int c = 0; c < NCH; c++) begin
            chan_sel = CW'(c); count_we = 1'b1; count_in = near_val();
            compare_we = 1'b1; compare_in = count_in + 32'($urandom_range(0, 6)) - 32'd3;
            set_cfg(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            tick();
        end
        idle();
        for (int cyc = 0; cyc < 600; cyc++) begin
            chan_sel   = CW'($urandom_range(0, 7));
            count_we   = ($urandom_range(0, 9) == 0);
            count_in   = near_val();
            compare_we = ($urandom_range(0, 9) == 0);
            compare_in = near_val();
            config_we  = ($urandom_range(0, 11) == 0);
            count_en_in = ($urandom_range(0, 3) != 0); count_dir_in = 1'($urandom_range(0, 1));
            count_ire_in = 1'($urandom_range(0, 1)); count_mode_in = 2'($urandom_range(0, 3));
            irq_clr_we = ($urandom_range(0, 7) == 0);
            irq_clr_in = 2'($urandom_range(0, 3));
            tick();
            ch = int'(chan_sel);
            if (ch < NCH) begin
                e_cnt = m_cnt[ch]; e_cmp = m_cmp[ch]; e_en = m_en[ch]; e_dir = m_dir[ch];
                e_ire = m_ire[ch]; e_mode = m_mode[ch]; e_pend = m_pend[ch]; e_lt = (m_cnt[ch] < m_cmp[ch]);
            end else begin
                e_cnt = 32'd0; e_cmp = 32'd0; e_en = 1'b0; e_dir = 1'b0;
                e_ire = 1'b0; e_mode = 2'd0; e_pend = 2'b00; e_lt = 1'b0;
            end
            n_cmp++;
            if (count_out !== e_cnt || compare_out !== e_cmp || count_en_out !== e_en ||
                count_dir_out !== e_dir || count_ire_out !== e_ire || count_mode_out !== e_mode ||
                irq_pending_out !== e_pend || count_lt_cmp_out !== e_lt || irq_out !== m_irq) begin
                n_bad++;
                $display("FAIL rand cyc%0d sel%0d: cnt=%h cmp=%h en%b dir%b ire%b mode%0d pend%b lt%b irq%b, want cnt=%h cmp=%h en%b dir%b ire%b mode%0d pend%b lt%b irq%b",
                         cyc, ch, count_out, compare_out, count_en_out, count_dir_out, count_ire_out,
                         count_mode_out, irq_pending_out, count_lt_cmp_out, irq_out,
                         e_cnt, e_cmp, e_en, e_dir, e_ire, e_mode, e_pend, e_lt, m_irq);
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        chan_sel = 3'd0; count_we = 1'b1; count_in = MAXV - 32'd1; set_cfg(1'b1, 1'b0, 1'b1, 2'd0);
        tick(); idle();
        repeat (3) tick();
        n_cmp++;
        if (irq_out !== 1'b1 || count_out !== 32'd1) begin
            n_bad++;
            $display("FAIL midrst_pre: irq=%b count=%0d, want 1/1", irq_out, count_out);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (irq_out !== 1'b0 || count_out !== 32'd0 || count_en_out !== 1'b0 ||
            compare_out !== 32'd1000 || irq_pending_out !== 2'b00 || count_ire_out !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_async: irq=%b count=%0d en=%b cmp=%0d pend=%b ire=%b, want 0/0/0/1000/00/0",
                     irq_out, count_out, count_en_out, compare_out, irq_pending_out, count_ire_out);
        end
        #2 reset = 1'b0;
        tick(); tick();
        n_cmp++;
        if (count_out !== 32'd0 || count_en_out !== 1'b0 || irq_out !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_after: count=%0d en=%b irq=%b, want 0/0/0", count_out, count_en_out, irq_out);
        end
    endtask

    initial begin
        test_reset();
        test_compare_ch0();
        test_saturate_ch1();
        test_oneshot_ch2();
        test_wrap_ch3();
        test_invalid_sel();
        test_concurrent_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
